// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO read port and sends each as an 8N1 UART frame, LSB first
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int RD_LATENCY   = 1
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_Q,
    output logic       FIFO_RDEN,
    output logic       UART_TX,
    output logic       BUSY
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [1:0]    r_wait;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_rden;
    logic          r_tx;
    logic          r_busy;
    logic          w_bit_end;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign FIFO_RDEN = r_rden;
    assign UART_TX   = r_tx;
    assign BUSY      = r_busy;
    // pop / wait-for-data / start / 8 data / stop sequencer; the shift register moves toward bit 0
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_wait  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_rden  <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_rden <= 1'b0;
            case (r_state)
                S_IDLE: if (!FIFO_EMPTY) begin
                    r_rden  <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= S_POP;
                end
                S_POP: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (r_wait == WAIT_LAST) begin
                    r_shift <= FIFO_Q;
                    r_tx    <= 1'b0;
                    r_baud  <= '0;
                    r_state <= S_START;
                end else begin
                    r_wait <= r_wait + 2'd1;
                end
                S_START: if (w_bit_end) begin
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_state <= S_DATA;
                end else begin
                    r_baud <= r_baud + BW'(1);
                end
                S_DATA: if (w_bit_end) begin
                    r_baud <= '0;
                    r_bit  <= r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end else begin
                    r_baud <= r_baud + BW'(1);
                end
                S_STOP: if (w_bit_end) begin
                    r_baud  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end else begin
                    r_baud <= r_baud + BW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two instances (4 clk/bit latency 1, 234 clk/bit latency 3) against a cycle-count model
module tb_fifo_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] empty = 2'b11;
    logic [1:0] rden, tx, busy;
    logic [7:0] q [2];
    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .RD_LATENCY(1)) u0 (
        .CLOCK(clk), .RESET_N(rst_n), .FIFO_EMPTY(empty[0]), .FIFO_Q(q[0]),
        .FIFO_RDEN(rden[0]), .UART_TX(tx[0]), .BUSY(busy[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(234), .RD_LATENCY(3)) u1 (
        .CLOCK(clk), .RESET_N(rst_n), .FIFO_EMPTY(empty[1]), .FIFO_Q(q[1]),
        .FIFO_RDEN(rden[1]), .UART_TX(tx[1]), .BUSY(busy[1]));

    function automatic int lat(input int d);
        return d ? 3 : 1;
    endfunction
    function automatic int cpb(input int d);
        return d ? 234 : 4;
    endfunction

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [7:0] fmem [2][256];
    int ftail [2] = '{0, 0};
    int fhead [2] = '{0, 0};
    int xhead [2] = '{0, 0};
    int pend  [2] = '{0, 0};
    logic [7:0] pbyte [2];
    logic [1:0] mask = 2'b00;
    int k [2] = '{-1, -1};
    logic [7:0] mbyte [2];
    logic [1:0] prev_ok = 2'b00;
    logic [1:0] prev_empty = 2'b11;
    int rden_cnt  [2] = '{0, 0};
    int rden_cyc  [2] = '{0, 0};
    int busy_fall [2] = '{0, 0};
    int tx_fall   [2] = '{0, 0};
    logic [1:0] prev_busy = 2'b00;
    logic [1:0] prev_tx = 2'b11;
    int dec_t   [2] = '{-1, -1};
    int dec_cnt [2] = '{0, 0};
    logic [9:0] dec_sh [2];
    logic [7:0] dec_b [2][64];
    logic [9:0] dec_f [2][64];
    int dec_s [2][64];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input logic [7:0] v);
        fmem[d][ftail[d] % 256] = v;
        ftail[d]++;
    endtask

    task automatic wait_dec(input int d, input int n, input int lim);
        int t = 0;
        while (dec_cnt[d] < n && t < lim) begin
            @(posedge clk);
            t++;
        end
        chk("decode within budget", int'(dec_cnt[d] >= n), 1);
        #1;
    endtask

    // reference model, compare, line decoder and FIFO read-port model, all once per cycle mid-period
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int e_tx, b;
            if (!rst_n) begin
                k[d] = -1;
                prev_ok[d] = 1'b0;
            end else begin
                if (k[d] >= 0) k[d]++;
                if (k[d] == lat(d) + 1 + 10 * cpb(d)) k[d] = -1;
                if (k[d] < 0 && prev_ok[d] && !prev_empty[d]) begin
                    k[d] = 0;
                    mbyte[d] = fmem[d][xhead[d] % 256];
                    xhead[d]++;
                end
                prev_ok[d] = (k[d] < 0);
            end
            e_tx = 1;
            if (k[d] > lat(d)) begin
                b = (k[d] - lat(d) - 1) / cpb(d);
                e_tx = (b == 0) ? 0 : (b == 9) ? 1 : int'(mbyte[d][b-1]);
            end
            chk(d ? "u1 rden/busy/tx" : "u0 rden/busy/tx", int'({rden[d], busy[d], tx[d]}),
                (k[d] == 0 ? 4 : 0) + (k[d] >= 0 ? 2 : 0) + e_tx);
            if (rden[d]) begin
                rden_cnt[d]++;
                rden_cyc[d] = cyc;
            end
            if (prev_busy[d] && !busy[d]) busy_fall[d] = cyc;
            if (!rst_n) dec_t[d] = -1;
            else if (dec_t[d] < 0) begin
                if (prev_tx[d] && !tx[d]) begin
                    dec_t[d] = 0;
                    tx_fall[d] = cyc;
                end
            end else dec_t[d]++;
            if (dec_t[d] >= 0 && dec_t[d] % cpb(d) == cpb(d) / 2) begin
                dec_sh[d] = {tx[d], dec_sh[d][9:1]};
                if (dec_t[d] / cpb(d) == 9) begin
                    dec_b[d][dec_cnt[d] % 64] = dec_sh[d][8:1];
                    dec_f[d][dec_cnt[d] % 64] = dec_sh[d];
                    dec_s[d][dec_cnt[d] % 64] = tx_fall[d];
                    dec_cnt[d]++;
                    dec_t[d] = -1;
                end
            end
            prev_busy[d] = busy[d];
            prev_tx[d] = tx[d];
            if (pend[d] > 0) begin
                pend[d]--;
                q[d] = (pend[d] == 0) ? pbyte[d] : 8'($urandom);
            end else q[d] = 8'($urandom);
            if (rden[d]) begin
                pbyte[d] = fmem[d][fhead[d] % 256];
                fhead[d]++;
                pend[d] = lat(d);
            end
            empty[d] = (fhead[d] == ftail[d]) | mask[d];
            prev_empty[d] = empty[d];
        end
    end

    initial begin
        int base, rb, t, h0, pushed;
        #1 rst_n = 1'b0;
        push(0, 8'h65);
        repeat (5) @(posedge clk);
        chk("no pop during reset", rden_cnt[0], 0);
        #1 rst_n = 1'b1;
        wait_dec(0, 1, 200);
        repeat (5) @(posedge clk);
        #1;
        chk("0x65 line bits", int'(dec_f[0][0]), 10'h2CA);
        chk("0x65 pops", rden_cnt[0], 1);
        chk("0x65 frame cycles", busy_fall[0] - dec_s[0][0], 40);
        chk("0x65 pop to start", dec_s[0][0] - rden_cyc[0], 2);

        base = dec_cnt[0];
        rb = rden_cnt[0];
        push(0, 8'h65);
        push(0, 8'h66);
        push(0, 8'h67);
        wait_dec(0, base + 3, 500);
        chk("burst pops", rden_cnt[0] - rb, 3);
        chk("burst byte 0", int'(dec_b[0][base]), 8'h65);
        chk("burst byte 1", int'(dec_b[0][base+1]), 8'h66);
        chk("burst byte 2", int'(dec_b[0][base+2]), 8'h67);
        chk("burst spacing 0", dec_s[0][base+1] - dec_s[0][base], 43);
        chk("burst spacing 1", dec_s[0][base+2] - dec_s[0][base+1], 43);

        repeat (10) @(posedge clk);
        rb = rden_cnt[0];
        repeat (1000) @(posedge clk);
        #1 chk("empty 1000 cycles pops", rden_cnt[0] + rden_cnt[1] - rb, 0);

        rb = rden_cnt[0];
        push(0, 8'hA5);
        push(0, 8'h5A);
        t = 0;
        while (rden_cnt[0] == rb && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("0xA5 popped", rden_cnt[0] - rb, 1);
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (cyc != rden_cyc[0] + 18 && t < 50);
        #2 chk("0xA5 bit3 before reset", int'(tx[0]), 0);
        rst_n = 1'b0;
        #1 chk("tx high on async reset", int'(tx[0]), 1);
        chk("busy low on async reset", int'(busy[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = dec_cnt[0];
        wait_dec(0, base + 1, 200);
        chk("byte after reset", int'(dec_b[0][base]), 8'h5A);
        chk("pops across reset", rden_cnt[0] - rb, 2);

        push(1, 8'h3C);
        wait_dec(1, 1, 3000);
        repeat (150) @(posedge clk);
        #1;
        chk("slow byte", int'(dec_b[1][0]), 8'h3C);
        chk("slow pops", rden_cnt[1], 1);
        chk("slow pop to start", dec_s[1][0] - rden_cyc[1], 4);
        chk("slow frame cycles", busy_fall[1] - dec_s[1][0], 2340);

        base = dec_cnt[0];
        h0 = ftail[0];
        pushed = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (pushed < 40 && $urandom_range(0, 19) == 0) begin
                push(0, 8'($urandom));
                pushed++;
            end
            if ($urandom_range(0, 15) == 0) mask[0] = ~mask[0];
        end
        mask = 2'b00;
        wait_dec(0, base + pushed, 3000);
        for (int i = 0; i < pushed; i++)
            chk("random byte", int'(dec_b[0][(base + i) % 64]), int'(fmem[0][(h0 + i) % 256]));
        repeat (60) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
